wb_burst_initiator: RTL and testbench

- Wishbone classic initiator that drives the neuron network's Wishbone target port from a simple command/stream interface.
- Typical use: a host-side sequencer or test controller issues bursts such as "write 8 spike words to IMEM base", "write param word", or "read 8 words from OMEM base".
- One command at a time; consecutive word addresses; per-beat ack timeout with error report.

---
 rtl/wb_burst_initiator.sv | 192 +++++++++++++++++++
 tb/tb_wb_burst_initiator.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_initiator.sv
// rtl/wb_burst_initiator.sv - Wishbone classic burst initiator driven by a command/stream interface
// One command at a time; consecutive beat addresses, per-beat ack timeout with error pulse.
module wb_burst_initiator #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_STEP      = 4,
  localparam int LW            = $clog2(MAX_LEN) + 1,
  localparam int TW            = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [31:0]   cmd_adr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic          wdata_valid_i,
  output logic          wdata_ready_o,
  input  logic [31:0]   wdata_i,
  output logic          rdata_valid_o,
  input  logic          rdata_ready_i,
  output logic [31:0]   rdata_o,
  output logic          done_o,
  output logic          err_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic [3:0]    wbm_sel_o,
  output logic [31:0]   wbm_adr_o,
  output logic [31:0]   wbm_dat_o,
  input  logic          wbm_ack_i,
  input  logic [31:0]   wbm_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BUS,
    S_RESP,
    S_DONE
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_we, w_we_nxt;
  logic [LW-1:0] r_beats, w_beats_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  logic          r_cyc, w_cyc_nxt;
  logic          r_stb, w_stb_nxt;
  logic [31:0]   r_adr, w_adr_nxt;
  logic [31:0]   r_dat, w_dat_nxt;
  logic [31:0]   r_rdata, w_rdata_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic [LW-1:0] w_eff_len;
  logic          w_ack;

  // Acks are only meaningful while a strobe is out; stray or late acks fall through.
  assign w_ack = wbm_ack_i & r_stb;

  always_comb begin
    w_eff_len = cmd_len_i;
    if (cmd_len_i == '0) begin
      w_eff_len = LW'(1);
    end else if (cmd_len_i > LW'(MAX_LEN)) begin
      w_eff_len = LW'(MAX_LEN);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_beats <= '0;
      r_tmo   <= '0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_adr   <= '0;
      r_dat   <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_we    <= w_we_nxt;
      r_beats <= w_beats_nxt;
      r_tmo   <= w_tmo_nxt;
      r_cyc   <= w_cyc_nxt;
      r_stb   <= w_stb_nxt;
      r_adr   <= w_adr_nxt;
      r_dat   <= w_dat_nxt;
      r_rdata <= w_rdata_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = r_we;
    w_beats_nxt = r_beats;
    w_tmo_nxt   = r_tmo;
    w_cyc_nxt   = r_cyc;
    w_stb_nxt   = r_stb;
    w_adr_nxt   = r_adr;
    w_dat_nxt   = r_dat;
    w_rdata_nxt = r_rdata;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_we_nxt    = cmd_we_i;
          w_adr_nxt   = cmd_adr_i;
          w_beats_nxt = w_eff_len;
          w_tmo_nxt   = '0;
          w_cyc_nxt   = 1'b1;
          w_stb_nxt   = ~cmd_we_i;
          w_state_nxt = cmd_we_i ? S_FETCH : S_BUS;
        end
      end
      S_FETCH: begin
        if (wdata_valid_i) begin
          w_dat_nxt   = wdata_i;
          w_stb_nxt   = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        if (w_ack) begin
          w_stb_nxt   = 1'b0;
          w_tmo_nxt   = '0;
          w_beats_nxt = r_beats - LW'(1);
          if (!r_we) begin
            w_rdata_nxt = wbm_dat_i;
            w_state_nxt = S_RESP;
          end else if (r_beats == LW'(1)) begin
            w_cyc_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_adr_nxt   = r_adr + 32'(ADDR_STEP);
            w_state_nxt = S_FETCH;
          end
        end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
          // Abort: remaining beats are dropped, no further write data is pulled.
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_tmo_nxt   = '0;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_RESP: begin
        // r_beats was already decremented on the ack, so zero means this was the last word.
        if (rdata_ready_i) begin
          if (r_beats == '0) begin
            w_cyc_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_adr_nxt   = r_adr + 32'(ADDR_STEP);
            w_stb_nxt   = 1'b1;
            w_state_nxt = S_BUS;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign cmd_ready_o   = (r_state == S_IDLE);
  assign wdata_ready_o = (r_state == S_FETCH);
  assign rdata_valid_o = (r_state == S_RESP);
  assign rdata_o       = r_rdata;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign wbm_cyc_o     = r_cyc;
  assign wbm_stb_o     = r_stb;
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = 4'hF;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;

endmodule

// File: tb/tb_wb_burst_initiator.sv
// tb/tb_wb_burst_initiator.sv - self-checking bench for wb_burst_initiator
// Environment process models the Wishbone target and the stream endpoints; tests compare against burst arithmetic.
module tb_wb_burst_initiator;
  localparam int MAX_LEN        = 16;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int LW             = $clog2(MAX_LEN) + 1;

  logic          wb_clk_i;
  logic          wb_rst_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_we_i = 1'b0;
  logic [31:0]   cmd_adr_i = '0;
  logic [LW-1:0] cmd_len_i = '0;
  logic          wdata_valid_i = 1'b0;
  logic          wdata_ready_o;
  logic [31:0]   wdata_i = '0;
  logic          rdata_valid_o;
  logic          rdata_ready_i = 1'b0;
  logic [31:0]   rdata_o;
  logic          done_o, err_o;
  logic          wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]    wbm_sel_o;
  logic [31:0]   wbm_adr_o, wbm_dat_o;
  logic          wbm_ack_i = 1'b0;
  logic [31:0]   wbm_dat_i = '0;

  wb_burst_initiator #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ADDR_STEP(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .rdata_valid_o(rdata_valid_o), .rdata_ready_i(rdata_ready_i), .rdata_o(rdata_o),
    .done_o(done_o), .err_o(err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;

  int          ack_delay = 1;
  int          wait_cnt = 0;
  logic [31:0] rd_base = '0;
  bit          stray_req = 1'b0;
  logic [31:0] b_adr[$];
  logic        b_we[$];
  logic [31:0] b_dat[$];
  logic [31:0] wq[$];
  int          wpop = 0, wvalid_pct = 100, wstall_at = -1, wstall_left = 0;
  bit          w_hs = 1'b0;
  logic [31:0] rgot[$];
  int          rready_pct = 100, rstall_left = 0;
  bit          r_hold = 1'b0;
  logic [31:0] r_prev = '0;
  int          done_cnt = 0, err_cnt = 0, bad_inv = 0;
  bit          prev_ack = 1'b0, prev_done = 1'b0;
  int          stb_run = 0, stb_run_max = 0, rvalid_cyc = 0, fetch_cyc = 0, cyc_gap = 0;

  // Environment runs 1 ns after each edge; tests run 2 ns after, so counters are settled when read.
  always @(posedge wb_clk_i) begin
    #1;
    if (w_hs && wq.size() > 0) begin
      void'(wq.pop_front());
      wpop++;
    end
    if (done_o === 1'b1) done_cnt++;
    if (err_o === 1'b1) err_cnt++;
    if (err_o === 1'b1 && done_o !== 1'b1) bad_inv++;
    if (done_o === 1'b1 && (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0)) bad_inv++;
    if (done_o === 1'b1 && prev_done) bad_inv++;
    if (wbm_stb_o === 1'b1 && wbm_cyc_o !== 1'b1) bad_inv++;
    if (wbm_sel_o !== 4'hF) bad_inv++;
    if (prev_ack && wbm_stb_o === 1'b1) bad_inv++;
    if (rdata_valid_o === 1'b1 && wbm_stb_o === 1'b1) bad_inv++;
    if (cmd_ready_o === 1'b1 && wbm_cyc_o === 1'b1) bad_inv++;
    if (wdata_ready_o === 1'b1 && (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b0)) bad_inv++;
    if (r_hold && (rdata_valid_o !== 1'b1 || rdata_o !== r_prev)) bad_inv++;
    prev_done = (done_o === 1'b1);
    stb_run = (wbm_stb_o === 1'b1) ? stb_run + 1 : 0;
    if (stb_run > stb_run_max) stb_run_max = stb_run;
    if (rdata_valid_o === 1'b1) rvalid_cyc++;
    if (wdata_ready_o === 1'b1) fetch_cyc++;

    wbm_ack_i = 1'b0;
    wbm_dat_i = $urandom();
    if (!wb_rst_i && wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1 && ack_delay >= 0) begin
      if (wait_cnt >= ack_delay) begin
        wbm_ack_i = 1'b1;
        wait_cnt = 0;
        b_adr.push_back(wbm_adr_o);
        b_we.push_back(wbm_we_o);
        b_dat.push_back(wbm_dat_o);
        wbm_dat_i = rd_base + 32'(b_adr.size() - 1);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_ack = wbm_ack_i;
    if (stray_req) wbm_ack_i = 1'b1;

    wdata_valid_i = 1'b0;
    if (wq.size() > 0) begin
      if (wstall_left > 0 && wpop == wstall_at && wdata_ready_o === 1'b1) wstall_left--;
      else if ($urandom_range(0, 99) < wvalid_pct) wdata_valid_i = 1'b1;
    end
    wdata_i = (wq.size() > 0) ? wq[0] : $urandom();
    w_hs = wdata_valid_i && (wdata_ready_o === 1'b1);

    rdata_ready_i = 1'b0;
    if (rdata_valid_o === 1'b1 && rstall_left > 0) rstall_left--;
    else if ($urandom_range(0, 99) < rready_pct) rdata_ready_i = 1'b1;
    if (rdata_valid_o === 1'b1 && rdata_ready_i) rgot.push_back(rdata_o);
    r_hold = (rdata_valid_o === 1'b1) && !rdata_ready_i;
    r_prev = rdata_o;
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #2;
  endtask

  function automatic int eff_len(input int len);
    return (len == 0) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
  endfunction

  task automatic start_cmd(input bit we, input logic [31:0] adr, input int len);
    int n;
    b_adr.delete(); b_we.delete(); b_dat.delete(); rgot.delete();
    stb_run_max = 0; rvalid_cyc = 0; fetch_cyc = 0; cyc_gap = 0;
    n = 0;
    while (cmd_ready_o !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_len_i = LW'(len);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic run_cmd(input bit we, input logic [31:0] adr, input int len);
    int n;
    start_cmd(we, adr, len);
    n = 0;
    while (done_o !== 1'b1 && n < 2000) begin
      if (wbm_cyc_o !== 1'b1) cyc_gap++;
      tick();
      n++;
    end
    if (done_o !== 1'b1) begin
      checks++; failures++;
      $display("FAIL done_wait: done_o=%b after %0d cycles, required 1", done_o, n);
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    wb_rst_i = 1'b1;
    repeat (3) tick();
    got = {wbm_cyc_o, wbm_stb_o, wbm_we_o, done_o, err_o, rdata_valid_o, cmd_ready_o, wdata_ready_o};
    checks++; if (got !== 8'b0000_0010) begin failures++; $display("FAIL reset_ctrl: got %b required %b", got, 8'b0000_0010); end
    checks++; if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL reset_data: adr=%h dat=%h rdata=%h required all 0", wbm_adr_o, wbm_dat_o, rdata_o); end
    checks++; if (wbm_sel_o !== 4'hF) begin failures++; $display("FAIL reset_sel: got %h required f", wbm_sel_o); end
    wb_rst_i = 1'b0;
    tick();
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", cmd_ready_o); end
  endtask

  task automatic test_single_write();
    int d0, e0, i0;
    d0 = done_cnt; e0 = err_cnt; i0 = bad_inv;
    wq.delete(); wq.push_back(32'hDEADBEEF);
    ack_delay = 0; wvalid_pct = 100;
    run_cmd(1'b1, 32'h8000_0000, 1);
    checks++; if (b_adr.size() != 1) begin failures++; $display("FAIL sw_beats: got %0d required 1", b_adr.size()); end
    else begin
      checks++; if (b_adr[0] !== 32'h8000_0000) begin failures++; $display("FAIL sw_adr: got %h required 80000000", b_adr[0]); end
      checks++; if (b_dat[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_dat: got %h required deadbeef", b_dat[0]); end
      checks++; if (b_we[0] !== 1'b1) begin failures++; $display("FAIL sw_we: got %b required 1", b_we[0]); end
    end
    checks++; if (stb_run_max != 1) begin failures++; $display("FAIL sw_stb_len: got %0d required 1", stb_run_max); end
    checks++; if (wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL sw_cyc_drop: got %b required 0", wbm_cyc_o); end
    tick();
    checks++; if (done_cnt != d0 + 1 || err_cnt != e0) begin
      failures++; $display("FAIL sw_done: done=%0d err=%0d required 1 and 0", done_cnt - d0, err_cnt - e0); end
    checks++; if (cmd_ready_o !== 1'b1) begin failures++; $display("FAIL sw_idle: cmd_ready=%b required 1", cmd_ready_o); end
    checks++; if (bad_inv != i0) begin failures++; $display("FAIL sw_protocol: %0d violations required 0", bad_inv - i0); end
  endtask

  task automatic test_read_burst();
    int d0, i0;
    d0 = done_cnt; i0 = bad_inv;
    ack_delay = 1; rready_pct = 100; rd_base = 32'h100;
    run_cmd(1'b0, 32'h8004_0000, 8);
    tick();
    checks++; if (b_adr.size() != 8 || rgot.size() != 8) begin
      failures++; $display("FAIL rb_beats: beats=%0d words=%0d required 8", b_adr.size(), rgot.size()); end
    for (int i = 0; i < 8 && i < b_adr.size() && i < rgot.size(); i++) begin
      checks++; if (b_adr[i] !== 32'h8004_0000 + 32'(4 * i) || b_we[i] !== 1'b0) begin
        failures++; $display("FAIL rb_adr[%0d]: got %h we=%b required %h we=0", i, b_adr[i], b_we[i], 32'h8004_0000 + 32'(4 * i)); end
      checks++; if (rgot[i] !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL rb_data[%0d]: got %h required %h", i, rgot[i], 32'h100 + 32'(i)); end
    end
    checks++; if (cyc_gap != 0) begin failures++; $display("FAIL rb_cyc_held: %0d gaps required 0", cyc_gap); end
    checks++; if (done_cnt != d0 + 1) begin failures++; $display("FAIL rb_done: got %0d pulses required 1", done_cnt - d0); end
    checks++; if (bad_inv != i0) begin failures++; $display("FAIL rb_protocol: %0d violations required 0", bad_inv - i0); end
  endtask

  task automatic test_write_stall();
    int e0, i0;
    e0 = err_cnt; i0 = bad_inv;
    wq.delete();
    for (int i = 0; i < 3; i++) wq.push_back(32'hA5A5_0000 + 32'(i));
    wpop = 0; wstall_at = 1; wstall_left = 5; wvalid_pct = 100; ack_delay = 1;
    run_cmd(1'b1, 32'h0000_1000, 3);
    checks++; if (b_adr.size() != 3) begin failures++; $display("FAIL ws_beats: got %0d required 3", b_adr.size()); end
    for (int i = 0; i < 3 && i < b_adr.size(); i++) begin
      checks++; if (b_adr[i] !== 32'h1000 + 32'(4 * i) || b_dat[i] !== 32'hA5A5_0000 + 32'(i)) begin
        failures++; $display("FAIL ws_beat[%0d]: adr=%h dat=%h required %h %h", i, b_adr[i], b_dat[i],
                             32'h1000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i)); end
    end
    checks++; if (fetch_cyc != 8) begin failures++; $display("FAIL ws_fetch_cycles: got %0d required 8", fetch_cyc); end
    checks++; if (err_cnt != e0 || cyc_gap != 0) begin
      failures++; $display("FAIL ws_no_abort: err=%0d cyc_gaps=%0d required 0 0", err_cnt - e0, cyc_gap); end
    checks++; if (bad_inv != i0) begin failures++; $display("FAIL ws_protocol: %0d violations required 0", bad_inv - i0); end
    wstall_at = -1;
  endtask

  task automatic test_read_backpressure();
    int i0;
    i0 = bad_inv;
    ack_delay = 1; rready_pct = 100; rstall_left = 4; rd_base = 32'hC0DE_0000;
    run_cmd(1'b0, 32'h0000_2000, 2);
    checks++; if (rvalid_cyc != 6) begin failures++; $display("FAIL rp_valid_cycles: got %0d required 6", rvalid_cyc); end
    checks++; if (rgot.size() != 2 || b_adr.size() != 2) begin
      failures++; $display("FAIL rp_beats: words=%0d beats=%0d required 2", rgot.size(), b_adr.size()); end
    else begin
      checks++; if (rgot[0] !== 32'hC0DE_0000 || rgot[1] !== 32'hC0DE_0001) begin
        failures++; $display("FAIL rp_data: got %h %h required c0de0000 c0de0001", rgot[0], rgot[1]); end
      checks++; if (b_adr[1] !== 32'h2004) begin failures++; $display("FAIL rp_adr: got %h required 00002004", b_adr[1]); end
    end
    checks++; if (bad_inv != i0) begin failures++; $display("FAIL rp_hold: %0d violations required 0", bad_inv - i0); end
  endtask

  task automatic test_timeout();
    int d0, e0, p0;
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back(32'h7700_0000 + 32'(i));
    d0 = done_cnt; e0 = err_cnt; p0 = wpop;
    ack_delay = -1; wvalid_pct = 100;
    run_cmd(1'b1, 32'h0000_3000, 4);
    checks++; if (stb_run_max != TIMEOUT_CYCLES) begin
      failures++; $display("FAIL to_stb_cycles: got %0d required %0d", stb_run_max, TIMEOUT_CYCLES); end
    checks++; if (err_o !== 1'b1 || wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      failures++; $display("FAIL to_abort: err=%b cyc=%b stb=%b required 1 0 0", err_o, wbm_cyc_o, wbm_stb_o); end
    tick();
    checks++; if (cmd_ready_o !== 1'b1 || err_o !== 1'b0) begin
      failures++; $display("FAIL to_ready: cmd_ready=%b err=%b required 1 0", cmd_ready_o, err_o); end
    checks++; if (wpop - p0 != 1 || wq.size() != 3) begin
      failures++; $display("FAIL to_wdata: consumed=%0d left=%0d required 1 3", wpop - p0, wq.size()); end
    checks++; if (done_cnt != d0 + 1 || err_cnt != e0 + 1) begin
      failures++; $display("FAIL to_pulses: done=%0d err=%0d required 1 1", done_cnt - d0, err_cnt - e0); end
    wq.delete();
    ack_delay = 1;
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    repeat (3) tick();
    checks++; if (done_cnt != d0 + 1 || wbm_cyc_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL to_stray_ack: done=%0d cyc=%b ready=%b required 1 0 1", done_cnt - d0, wbm_cyc_o, cmd_ready_o); end
  endtask

  task automatic test_len_bounds();
    wq.delete(); wq.push_back(32'h0BAD_F00D);
    ack_delay = 0; wvalid_pct = 100;
    run_cmd(1'b1, 32'h0000_4000, 0);
    checks++; if (b_adr.size() != 1 || wq.size() != 0) begin
      failures++; $display("FAIL len0_beats: beats=%0d left=%0d required 1 0", b_adr.size(), wq.size()); end
    rd_base = 32'h0; rready_pct = 100;
    run_cmd(1'b0, 32'h0000_5000, 31);
    checks++; if (b_adr.size() != MAX_LEN) begin failures++; $display("FAIL clamp_beats: got %0d required %0d", b_adr.size(), MAX_LEN); end
  endtask

  task automatic test_wrap();
    ack_delay = 1; rready_pct = 100; rd_base = 32'h55;
    run_cmd(1'b0, 32'hFFFF_FFFC, 2);
    checks++; if (b_adr.size() != 2) begin failures++; $display("FAIL wrap_beats: got %0d required 2", b_adr.size()); end
    else begin
      checks++; if (b_adr[0] !== 32'hFFFF_FFFC || b_adr[1] !== 32'h0) begin
        failures++; $display("FAIL wrap_adr: got %h %h required fffffffc 00000000", b_adr[0], b_adr[1]); end
    end
  endtask

  task automatic test_reset_mid();
    int d0, n;
    d0 = done_cnt;
    ack_delay = 2; rready_pct = 100; rd_base = 32'h900;
    start_cmd(1'b0, 32'h0000_6000, 8);
    n = 0;
    while (!(b_adr.size() == 2 && wbm_stb_o === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    checks++; if (!(b_adr.size() == 2 && wbm_stb_o === 1'b1)) begin
      failures++; $display("FAIL rm_reach_beat3: beats=%0d stb=%b required 2 1", b_adr.size(), wbm_stb_o); end
    wb_rst_i = 1'b1;
    tick();
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || rdata_valid_o !== 1'b0 || done_o !== 1'b0) begin
      failures++; $display("FAIL rm_abort: cyc=%b stb=%b rvalid=%b done=%b required 0 0 0 0",
                           wbm_cyc_o, wbm_stb_o, rdata_valid_o, done_o); end
    checks++; if (wbm_adr_o !== 32'h0 || rdata_o !== 32'h0) begin
      failures++; $display("FAIL rm_clear: adr=%h rdata=%h required 0 0", wbm_adr_o, rdata_o); end
    wb_rst_i = 1'b0;
    repeat (4) tick();
    checks++; if (done_cnt != d0 || b_adr.size() != 2 || cmd_ready_o !== 1'b1) begin
      failures++; $display("FAIL rm_lost: done=%0d beats=%0d ready=%b required 0 2 1", done_cnt - d0, b_adr.size(), cmd_ready_o); end
  endtask

  task automatic test_random();
    bit          we;
    logic [31:0] adr;
    int          len, n, e0, i0;
    logic [31:0] exp_w[$];
    e0 = err_cnt; i0 = bad_inv;
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      adr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 15) * 4)) : $urandom();
      len = $urandom_range(0, 31);
      n = eff_len(len);
      ack_delay = $urandom_range(0, 3);
      wvalid_pct = $urandom_range(30, 100);
      rready_pct = $urandom_range(30, 100);
      rd_base = $urandom();
      wq.delete(); exp_w.delete();
      if (we) begin
        for (int i = 0; i < n; i++) begin
          exp_w.push_back($urandom());
          wq.push_back(exp_w[i]);
        end
      end
      run_cmd(we, adr, len);
      checks++; if (b_adr.size() != n) begin
        failures++; $display("FAIL rand_beats[%0d]: got %0d required %0d (len=%0d)", k, b_adr.size(), n, len); end
      for (int i = 0; i < n && i < b_adr.size(); i++) begin
        checks++; if (b_adr[i] !== adr + 32'(4 * i) || b_we[i] !== we) begin
          failures++; $display("FAIL rand_adr[%0d.%0d]: got %h we=%b required %h we=%b", k, i, b_adr[i], b_we[i], adr + 32'(4 * i), we); end
        if (we) begin
          checks++; if (b_dat[i] !== exp_w[i]) begin
            failures++; $display("FAIL rand_wdat[%0d.%0d]: got %h required %h", k, i, b_dat[i], exp_w[i]); end
        end else begin
          checks++; if (i >= rgot.size() || rgot[i] !== rd_base + 32'(i)) begin
            failures++; $display("FAIL rand_rdat[%0d.%0d]: words=%0d required %h", k, i, rgot.size(), rd_base + 32'(i)); end
        end
      end
      checks++; if (cyc_gap != 0 || wq.size() != 0) begin
        failures++; $display("FAIL rand_flow[%0d]: cyc_gaps=%0d wdata_left=%0d required 0 0", k, cyc_gap, wq.size()); end
    end
    checks++; if (err_cnt != e0) begin failures++; $display("FAIL rand_err: got %0d required 0", err_cnt - e0); end
    checks++; if (bad_inv != i0) begin failures++; $display("FAIL rand_protocol: %0d violations required 0", bad_inv - i0); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_burst();
    test_write_stall();
    test_read_backpressure();
    test_timeout();
    test_len_bounds();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
